thunderbird_seq: RTL and testbench

Parametrised tail-light sequencer, successor to the fixed three-lamp Thunderbird controller. It drives `LAMPS` lamps per side with a progressive outward turn sweep, a both-sides hazard flash and a steady brake overlay. An internal prescaler sets the step rate. Sits between the driver-input synchroniser and the lamp driver outputs.

---
 rtl/thunderbird_seq_pkg.sv | 23 ++
 rtl/thunderbird_seq_if.sv | 22 ++
 rtl/thunderbird_seq_prescaler.sv | 27 ++
 rtl/thunderbird_seq.sv | 117 +++++++++++
 tb/tb_thunderbird_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/thunderbird_seq_pkg.sv
// Shared types and helpers for the parametrised tail-light sequencer.
// The lamp mask helper is width-generic; callers cast to their lamp count.
package thunderbird_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } state_t;

  localparam int MAX_LAMPS = 32;

  function automatic logic [MAX_LAMPS-1:0] fill(input int k);
    logic [MAX_LAMPS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (i < k) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/thunderbird_seq_if.sv
// Driver requests in, lamp drive out.
// The sequencer is the slave; the input synchroniser side is the master.
interface thunderbird_seq_if #(
  parameter int LAMPS = 3
);
  logic             L;
  logic             R;
  logic             Haz;
  logic             Brk;
  logic [LAMPS-1:0] LLamp;
  logic [LAMPS-1:0] RLamp;

  modport master (
    output L, R, Haz, Brk,
    input  LLamp, RLamp
  );

  modport slave (
    input  L, R, Haz, Brk,
    output LLamp, RLamp
  );
endinterface

// File: rtl/thunderbird_seq_prescaler.sv
// Step-rate prescaler: tick every PRESCALE cycles.
// clr restarts the count so a freshly entered state gets a full step.
module tb_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic Rs,
  input  logic clr,
  output logic tick
);
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0] pc;

  assign tick = (pc == LAST);

  always_ff @(posedge Clk or negedge Rs) begin
    if (!Rs) begin
      pc <= '0;
    end else if (clr || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PCW'(1);
    end
  end
endmodule

// File: rtl/thunderbird_seq.sv
// Tail-light sequencer: outward turn sweep, hazard flash, brake overlay.
// Lamps are registered from the next-state decode so they move with the state.
module thunderbird_seq
  import thunderbird_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int PRESCALE = 1
) (
  input logic              Clk,
  input logic              Rs,
  thunderbird_seq_if.slave io
);
  localparam int KW = $clog2(LAMPS + 1);
  localparam logic [KW-1:0] KLAST = KW'(LAMPS);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             ph_q, ph_d;
  logic             tick;
  logic             clr;
  logic             haz_req;
  logic [LAMPS-1:0] lamp_l_d, lamp_r_d;
  logic [LAMPS-1:0] lamp_l_q, lamp_r_q;
  logic [LAMPS-1:0] sweep;
  logic [LAMPS-1:0] brk_fill;

  assign haz_req = io.Haz | (io.L & io.R);
  assign clr     = (state_d != state_q);

  tb_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .Clk  (Clk),
    .Rs   (Rs),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge Clk or negedge Rs) begin
    if (!Rs) begin
      state_q  <= IDLE;
      k_q      <= '0;
      ph_q     <= 1'b0;
      lamp_l_q <= '0;
      lamp_r_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ph_q     <= ph_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ph_d    = ph_q;
    unique case (state_q)
      IDLE: begin
        if (haz_req) begin
          state_d = HAZ;
          ph_d    = 1'b1;
        end else if (io.L) begin
          state_d = LEFT;
          k_d     = KW'(1);
        end else if (io.R) begin
          state_d = RIGHT;
          k_d     = KW'(1);
        end
      end
      LEFT, RIGHT: begin
        // a running sweep ignores its own request; only hazard cuts it short
        if (haz_req) begin
          state_d = HAZ;
          ph_d    = 1'b1;
          k_d     = '0;
        end else if (tick) begin
          if (k_q == KLAST) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      HAZ: begin
        if (tick) begin
          if (!haz_req) begin
            state_d = IDLE;
            ph_d    = 1'b0;
          end else begin
            ph_d = ~ph_q;
          end
        end
      end
    endcase
  end

  assign sweep    = LAMPS'(fill(int'(k_d)));
  assign brk_fill = {LAMPS{io.Brk}};

  always_comb begin
    lamp_l_d = brk_fill;
    lamp_r_d = brk_fill;
    unique case (state_d)
      IDLE:  ;
      LEFT:  lamp_l_d = sweep;
      RIGHT: lamp_r_d = sweep;
      HAZ: begin
        lamp_l_d = {LAMPS{ph_d}};
        lamp_r_d = {LAMPS{ph_d}};
      end
    endcase
  end

  assign io.LLamp = lamp_l_q;
  assign io.RLamp = lamp_r_q;
endmodule

// File: tb/tb_thunderbird_seq.sv
// Scoreboard bench for thunderbird_seq over three parameter sets.
// Stimulus pushes expected lamps; the monitor pops after each edge.
module tb_thunderbird_seq;

  logic clk = 1'b0;
  logic rs  = 1'b1;

  always #5 clk = ~clk;

  thunderbird_seq_if #(.LAMPS(3)) ifa ();
  thunderbird_seq_if #(.LAMPS(4)) ifb ();
  thunderbird_seq_if #(.LAMPS(3)) ifc ();

  thunderbird_seq #(.LAMPS(3), .PRESCALE(1)) dut_a (
    .Clk (clk),
    .Rs  (rs),
    .io  (ifa.slave)
  );

  thunderbird_seq #(.LAMPS(4), .PRESCALE(1)) dut_b (
    .Clk (clk),
    .Rs  (rs),
    .io  (ifb.slave)
  );

  thunderbird_seq #(.LAMPS(3), .PRESCALE(4)) dut_c (
    .Clk (clk),
    .Rs  (rs),
    .io  (ifc.slave)
  );

  typedef struct {
    int         id;
    logic [3:0] el;
    logic [3:0] er;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] act_l(input int id);
    case (id)
      0:       return {1'b0, ifa.LLamp};
      1:       return ifb.LLamp;
      default: return {1'b0, ifc.LLamp};
    endcase
  endfunction

  function automatic logic [3:0] act_r(input int id);
    case (id)
      0:       return {1'b0, ifa.RLamp};
      1:       return ifb.RLamp;
      default: return {1'b0, ifc.RLamp};
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic drive(input int id, input logic l, input logic r,
                       input logic h, input logic b);
    ifa.L = (id == 0) & l; ifa.R = (id == 0) & r;
    ifa.Haz = (id == 0) & h; ifa.Brk = (id == 0) & b;
    ifb.L = (id == 1) & l; ifb.R = (id == 1) & r;
    ifb.Haz = (id == 1) & h; ifb.Brk = (id == 1) & b;
    ifc.L = (id == 2) & l; ifc.R = (id == 2) & r;
    ifc.Haz = (id == 2) & h; ifc.Brk = (id == 2) & b;
  endtask

  // called at a negedge; expectation applies after the coming posedge
  task automatic step(input int id, input logic l, input logic r,
                      input logic h, input logic b,
                      input logic [3:0] el, input logic [3:0] er,
                      input string tag);
    exp_t x;
    drive(id, l, r, h, b);
    x.id = id; x.el = el; x.er = er; x.tag = tag;
    q.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, "_l"}, act_l(e.id), e.el);
      check({e.tag, "_r"}, act_r(e.id), e.er);
    end
  end

  initial begin
    logic [3:0] lp [4];
    logic [3:0] want;
    int p;
    lp = '{4'd1, 4'd3, 4'd7, 4'd0};
    drive(0, 0, 0, 0, 0);
    #1 rs = 1'b0;
    #11;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_l%0d", i), act_l(i), 4'd0);
      check($sformatf("reset_r%0d", i), act_r(i), 4'd0);
    end
    @(negedge clk);
    rs = 1'b1;

    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, 0, lp[i % 4], 4'd0, $sformatf("left%0d", i));
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, "left_end");

    for (int i = 0; i < 6; i++) begin
      want = (i % 2 == 0) ? 4'hF : 4'h0;
      step(1, 1, 1, 0, 0, want, want, $sformatf("haz%0d", i));
    end
    step(1, 1, 1, 0, 0, 4'hF, 4'hF, "haz_on");
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, "haz_exit");
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, "haz_idle");

    step(0, 0, 1, 0, 1, 4'd7, 4'd1, "brk1");
    step(0, 0, 1, 0, 1, 4'd7, 4'd3, "brk2");
    step(0, 0, 1, 0, 1, 4'd7, 4'd7, "brk3");
    step(0, 0, 0, 0, 1, 4'd7, 4'd7, "brk_idle");
    step(0, 0, 0, 0, 1, 4'd7, 4'd7, "brk_hold");
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, "brk_off");

    step(0, 1, 0, 0, 0, 4'd1, 4'd0, "noabort1");
    step(0, 0, 0, 0, 0, 4'd3, 4'd0, "noabort2");
    step(0, 0, 0, 0, 0, 4'd7, 4'd0, "noabort3");
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, "noabort_end");
    step(0, 1, 0, 0, 0, 4'd1, 4'd0, "pre1");
    step(0, 1, 0, 0, 0, 4'd3, 4'd0, "pre2");
    step(0, 1, 0, 1, 0, 4'd7, 4'd7, "pre_haz");
    step(0, 0, 0, 1, 0, 4'd0, 4'd0, "pre_off");
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, "pre_drop");

    step(0, 0, 1, 0, 0, 4'd0, 4'd1, "cross1");
    step(0, 1, 0, 0, 0, 4'd0, 4'd3, "cross2");
    step(0, 1, 0, 0, 0, 4'd0, 4'd7, "cross3");
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, "cross_gap");
    step(0, 1, 0, 0, 0, 4'd1, 4'd0, "cross_left1");
    step(0, 0, 0, 0, 0, 4'd3, 4'd0, "cross_left2");
    step(0, 0, 0, 0, 0, 4'd7, 4'd0, "cross_left3");
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, "cross_end");

    for (int n = 1; n <= 26; n++) begin
      p = (n - 1) % 13;
      want = (p < 4) ? 4'd1 : (p < 8) ? 4'd3 : (p < 12) ? 4'd7 : 4'd0;
      step(2, n <= 14, 0, 0, 0, want, 4'd0, $sformatf("pre4_%0d", n));
    end
    step(2, 0, 0, 0, 0, 4'd0, 4'd0, "pre4_idle");

    step(0, 1, 1, 0, 0, 4'd7, 4'd7, "rst_haz");
    #2 rs = 1'b0;
    #1;
    check("async_rst_l", act_l(0), 4'd0);
    check("async_rst_r", act_r(0), 4'd0);
    @(negedge clk);
    rs = 1'b1;
    step(0, 0, 1, 0, 0, 4'd0, 4'd1, "rel1");
    step(0, 0, 0, 0, 0, 4'd0, 4'd3, "rel2");

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
